// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver
//   Receiving end of the DAC SPI write link. All SPI pins are oversampled in
//   the clk_i domain. A frame (command field followed by a two's complement
//   sample, MSB first) is accepted when chip-select rises after exactly
//   FRAME_BITS SCK rising edges. Any other bit count raises frame_err_o.
//
// Ports
//   clk_i         system clock (50 MHz)
//   reset_i       synchronous, active-high reset
//   spi_clk_i     SPI clock from the writer, idle low
//   spi_mosi_i    serial data, MSB first, sampled on SCK rise
//   spi_cs_i      chip select, active low
//   dac_reset_ni  DAC reset, active low: clears outputs and aborts a frame
//   data_o        last accepted sample (two's complement)
//   cmd_o         last accepted command field
//   valid_o       one-cycle strobe, data_o/cmd_o updated
//   frame_err_o   one-cycle strobe, frame closed with a wrong bit count
//   is_idle_o     high when no frame is being shifted in
`timescale 1ns/1ps
module dac_spi_receiver #(
  parameter int FRAME_BITS  = 24,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               spi_clk_i,
  input  logic                               spi_mosi_i,
  input  logic                               spi_cs_i,
  input  logic                               dac_reset_ni,
  output logic signed [DATA_BITS-1:0]        data_o,
  output logic [FRAME_BITS-DATA_BITS-1:0]    cmd_o,
  output logic                               valid_o,
  output logic                               frame_err_o,
  output logic                               is_idle_o
);

  localparam int                 CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  // Bit counter saturates one past a full frame so overlong frames stay
  // distinguishable from a correct one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_MAX) begin
      return CNT_MAX;
    end
    return cnt + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dac_sync;
  logic [SYNC_STAGES-1:0] vld_sync;

  logic sck_p0;
  logic mosi_p0;
  logic cs_p0;
  logic dac_n_p0;
  logic sck_prev;
  logic cs_prev;

  logic sck_rise_p1;
  logic cs_rise_p1;
  logic cs_fall_p1;
  logic cs_p1;
  logic mosi_p1;
  logic dac_n_p1;
  logic vld_p1;

  state_t                  state;
  state_t                  state_d;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    valid_d;
  logic                    err_d;
  logic                    load;
  logic                    start;
  logic                    shift_en;

  // Stage p0: synchronizer chains, reset to the idle pin levels. vld_sync
  // fills with ones after reset so the FSM ignores levels that are still
  // the reset values rather than real pin samples.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dac_sync  <= '1;
      vld_sync  <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi_clk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_i};
      dac_sync  <= {dac_sync[SYNC_STAGES-2:0],  dac_reset_ni};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0],  1'b1};
    end
  end

  assign sck_p0   = sck_sync[SYNC_STAGES-1];
  assign mosi_p0  = mosi_sync[SYNC_STAGES-1];
  assign cs_p0    = cs_sync[SYNC_STAGES-1];
  assign dac_n_p0 = dac_sync[SYNC_STAGES-1];

  // Stage p1: edge flags registered together with the pin levels seen at
  // the same instant, so MOSI stays aligned with its SCK rise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_prev    <= 1'b0;
      cs_prev     <= 1'b1;
      sck_rise_p1 <= 1'b0;
      cs_rise_p1  <= 1'b0;
      cs_fall_p1  <= 1'b0;
      cs_p1       <= 1'b1;
      mosi_p1     <= 1'b0;
      dac_n_p1    <= 1'b1;
      vld_p1      <= 1'b0;
    end else begin
      sck_prev    <= sck_p0;
      cs_prev     <= cs_p0;
      sck_rise_p1 <= sck_p0 & ~sck_prev;
      cs_rise_p1  <= cs_p0 & ~cs_prev;
      cs_fall_p1  <= ~cs_p0 & cs_prev;
      cs_p1       <= cs_p0;
      mosi_p1     <= mosi_p0;
      dac_n_p1    <= dac_n_p0;
      vld_p1      <= vld_sync[SYNC_STAGES-1];
    end
  end

  // Stage p2: frame FSM. A CS rise always wins over an SCK rise in the
  // same cycle. DAC reset overrides everything and drops back to WAIT_IDLE
  // so a frame that is already under way is never picked up halfway.
  always_comb begin
    state_d  = state;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    shift_en = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (vld_p1 && cs_p1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall_p1) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise_p1) begin
          state_d = IDLE;
          if (bit_cnt == CNT_FULL) begin
            valid_d = 1'b1;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sck_rise_p1) begin
          shift_en = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (!dac_n_p1) begin
      state_d  = WAIT_IDLE;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      load     = 1'b0;
      start    = 1'b0;
      shift_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= WAIT_IDLE;
      bit_cnt     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      data_o      <= '0;
      cmd_o       <= '0;
    end else begin
      state       <= state_d;
      valid_o     <= valid_d;
      frame_err_o <= err_d;
      if (start) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= sat_inc(bit_cnt);
      end
      if (!dac_n_p1) begin
        data_o <= '0;
        cmd_o  <= '0;
      end else if (load) begin
        data_o <= $signed(shreg[DATA_BITS-1:0]);
        cmd_o  <= shreg[FRAME_BITS-1:DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_BITS-2:0], mosi_p1};
    end
  end

  assign is_idle_o = (state != SHIFT);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Testbench for dac_spi_receiver: directed frames from the bring-up list
// followed by randomized frames. Expected strobes are queued when CS is
// raised; a monitor pops them whenever the DUT strobes.
`timescale 1ns/1ps
module tb_dac_spi_receiver;

  localparam int FB = 24;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        dac_reset_n = 1'b1;
  logic [15:0] data;
  logic [7:0]  cmd;
  logic        valid;
  logic        ferr;
  logic        idle;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [7:0]  cmd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned cs_rise_cyc = 0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_cmd = '0;

  dac_spi_receiver #(
    .FRAME_BITS (24),
    .DATA_BITS  (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .spi_clk_i   (spi_clk),
    .spi_mosi_i  (spi_mosi),
    .spi_cs_i    (spi_cs),
    .dac_reset_ni(dac_reset_n),
    .data_o      (data),
    .cmd_o       (cmd),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .is_idle_o   (idle)
  );

  initial forever #10 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame of nbits bits (MSB first, from val[nbits-1]).
  // rst_at / dac_at >= 0 disturb the frame at that bit index.
  task automatic send_frame(input logic [31:0] val, input int nbits, input int half,
                            input int rst_at, input int dac_at);
    bit   disturbed;
    exp_t e;
    disturbed = 1'b0;
    spi_cs = 1'b0;
    wait_cyc(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_i = 1'b1;
        wait_cyc(2);
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_cmd", 32'(cmd), 32'h0);
        check("midrst_idle", 32'(idle), 32'h1);
        check("midrst_strobes", 32'({valid, ferr}), 32'h0);
        reset_i = 1'b0;
        m_data = '0;
        m_cmd = '0;
        disturbed = 1'b1;
      end
      if (i == dac_at) begin
        dac_reset_n = 1'b0;
        disturbed = 1'b1;
      end
      if (dac_at >= 0 && i == dac_at + 4) begin
        check("dacrst_data", 32'(data), 32'h0);
        check("dacrst_cmd", 32'(cmd), 32'h0);
        check("dacrst_idle", 32'(idle), 32'h1);
        dac_reset_n = 1'b1;
        m_data = '0;
        m_cmd = '0;
      end
      spi_mosi = val[nbits-1-i];
      wait_cyc(half);
      spi_clk = 1'b1;
      wait_cyc(half);
      spi_clk = 1'b0;
    end
    wait_cyc(half);
    if (!disturbed) begin
      if (nbits == FB) begin
        m_data = val[15:0];
        m_cmd  = val[23:16];
        e.is_err = 1'b0;
      end else begin
        e.is_err = 1'b1;
      end
      e.data = m_data;
      e.cmd  = m_cmd;
      exp_q.push_back(e);
    end
    spi_cs = 1'b1;
    cs_rise_cyc = cyc;
    wait_cyc(12);
  endtask

  // Monitor: every strobe must match the oldest queued expectation and
  // arrive four rising edges after CS was raised (edge N+3).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || ferr) begin
        check("strobe_exclusive", 32'(valid & ferr), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({valid, ferr}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'({valid, ferr}), e.is_err ? 32'h1 : 32'h2);
          check("data", 32'(data), 32'(e.data));
          check("cmd", 32'(cmd), 32'(e.cmd));
          check("latency", 32'(cyc - cs_rise_cyc), 32'd4);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          h;
    int          nb;

    reset_i = 1'b1;
    wait_cyc(4);
    check("reset_data", 32'(data), 32'h0);
    check("reset_cmd", 32'(cmd), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_idle", 32'(idle), 32'h1);
    reset_i = 1'b0;
    wait_cyc(6);
    check("post_reset_idle", 32'(idle), 32'h1);

    send_frame(32'h00_7FFF, 24, 5, -1, -1);
    send_frame(32'h03_8000, 24, 5, -1, -1);
    send_frame(32'h000A_BCDE, 20, 5, -1, -1);
    send_frame(32'h03FF_FFFF, 26, 5, -1, -1);
    send_frame(32'h00_1234, 24, 5, -1, -1);

    // Reset released while CS is already low and SCK toggling.
    reset_i = 1'b1;
    spi_cs = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) begin
        reset_i = 1'b0;
        m_data = '0;
        m_cmd = '0;
      end
      spi_mosi = i[0];
      wait_cyc(5);
      spi_clk = 1'b1;
      wait_cyc(5);
      spi_clk = 1'b0;
    end
    wait_cyc(5);
    spi_cs = 1'b1;
    wait_cyc(12);
    check("rel_data", 32'(data), 32'h0);
    check("rel_idle", 32'(idle), 32'h1);

    send_frame(32'h00_00A5, 24, 5, -1, -1);
    send_frame($urandom, 24, 5, 12, -1);
    send_frame(32'h05_ABCD, 24, 5, -1, -1);
    send_frame(32'h02_5A5A, 24, 5, -1, 8);
    send_frame(32'h00_FFFF, 24, 5, -1, -1);

    for (int k = 0; k < 30; k++) begin
      v  = $urandom;
      h  = int'($urandom_range(2, 6));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 24;
      send_frame(v, nb, h, -1, -1);
    end

    wait_cyc(20);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_receiver.md
Name: dac_spi_receiver

Overview:
- SPI responder: the receiving end of the DAC write link.
- Captures frames driven on chip-select, SPI clock and MOSI by our DAC writer.
- Delivers the decoded command byte and 16-bit sample with a one-cycle valid strobe.
- Used as an on-FPGA loopback target and as a synthesizable DAC model for board self-test.
- Implementation: oversamples all SPI pins in the 50 MHz system clock domain; no second clock.

Parameters:
- FRAME_BITS, 24, total bits per frame (command + data).
- DATA_BITS, 16, data field width (LSBs of the frame).
- SYNC_STAGES, 2, synchronizer flops per input pin (min 2).

Ports:
- clk_i  in  1  system clock, 50 MHz.
- reset_i  in  1  synchronous, active-high reset.
- spi_clk_i  in  1  SPI clock from the writer, idle low.
- spi_mosi_i  in  1  serial data, MSB first.
- spi_cs_i  in  1  chip select, active low.
- dac_reset_ni  in  1  DAC reset, active low.
- data_o  out  DATA_BITS  last valid sample, two's complement.
- cmd_o  out  FRAME_BITS-DATA_BITS  last valid command field.
- valid_o  out  1  one-cycle strobe: data_o/cmd_o updated.
- frame_err_o  out  1  one-cycle strobe: frame aborted with wrong bit count.
- is_idle_o  out  1  high when no frame is in progress.

Behaviour:
- Reset: clock and reset
  - Single clock clk_i; reset_i is synchronous, active-high, sampled on the rising clk_i edge.
  - During and after reset: data_o=0, cmd_o=0, valid_o=0, frame_err_o=0, is_idle_o=1.
  - Synchronizer flops reset to the idle pin levels: sck=0, cs=1, mosi=0.
- Input conditioning
  - spi_clk_i, spi_mosi_i, spi_cs_i and dac_reset_ni each pass through SYNC_STAGES flops.
  - A further "prev" register per pin gives edge detection: rise = s & !prev, fall = !s & prev.
  - Legal SPI clock: each high and low phase lasts ≥2 clk_i periods (SPI clk ≤ 12.5 MHz).
- State machine
  - WAIT_IDLE: entered from reset. Stays until synced cs=1, then goes to IDLE. This prevents starting mid-frame if CS is already low at reset release.
  - IDLE: is_idle_o=1. On cs fall: go to SHIFT, bit_cnt=0, shift register cleared.
  - SHIFT: is_idle_o=0.
    - On sck rise: shreg <= {shreg[FRAME_BITS-2:0], mosi_s}; bit_cnt increments, saturating at FRAME_BITS+1.
    - sck falls are ignored.
  - SHIFT on cs rise, bit_cnt==FRAME_BITS: register data_o=shreg[DATA_BITS-1:0] and cmd_o=shreg[FRAME_BITS-1:DATA_BITS]; pulse valid_o; go to IDLE.
  - SHIFT on cs rise, bit_cnt≠FRAME_BITS (including 0 and overflow): pulse frame_err_o; data_o/cmd_o unchanged; go to IDLE.
  - Simultaneous sck rise and cs rise in the same cycle: the sck edge is discarded; only the cs rise is processed.
- Latency
  - Let N be the first clk_i edge sampling spi_cs_i high (SYNC_STAGES=2).
  - valid_o (or frame_err_o) is high from edge N+3 to edge N+4, exactly one cycle.
  - data_o/cmd_o change on the same edge valid_o rises and hold until the next valid frame.
- DAC reset
  - While synced dac_reset_n=0: data_o and cmd_o are forced to 0; any frame in progress is discarded with no strobe.
  - State goes to WAIT_IDLE.
  - Reception resumes after dac_reset_n returns high and cs is seen high.
- Mid-operation reset: reset_i during SHIFT discards the frame; no strobe; outputs return to reset values.
- valid_o and frame_err_o are never high in the same cycle.

Test Plan:
- Frame 0x00_7FFF, then frame 0x03_8000, each with 24 SCK pulses at 5 MHz → valid_o pulses once per frame.
  - First frame: data_o=0x7FFF, cmd_o=0x00.
  - Second frame: data_o=0x8000, cmd_o=0x03.
  - valid_o goes high exactly 3 clk edges after the first edge sampling CS high.
- Frame with 20 SCK pulses, then CS high → frame_err_o single pulse; data_o keeps the previous value 0x8000; valid_o stays 0.
- Frame with 26 SCK pulses → frame_err_o pulse, no valid_o.
- Then a correct 24-bit frame 0x00_1234 → valid_o with data_o=0x1234.
- Release reset_i while spi_cs_i=0 and SCK is toggling; CS rises after 10 bits → no strobe.
  - Next full frame 0x00_00A5 → data_o=0x00A5.
- Assert reset_i at bit 12 of a frame → outputs return to 0 and is_idle_o=1.
  - Complete that frame → no strobe; the following frame is received correctly.
- dac_reset_ni low during a frame → data_o=0 and no strobe.
  - After dac_reset_ni goes high, frame 0x00_FFFF → data_o=0xFFFF.
